gf2mz_mul_engine: RTL and testbench



---
 rtl/gf2mz_pkg.sv | 49 ++++
 rtl/gf2m_mul.sv | 76 +++++++
 rtl/gf2mz_pp_fold.sv | 28 ++
 rtl/gf2mz_mul_engine.sv | 261 ++++++++++++++++++++++++++
 tb/tb_gf2mz_mul_engine.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gf2mz_pkg.sv
`default_nettype none
// ============================================================================
// Package  : gf2mz_pkg
// Purpose  : Shared definitions for the GF(2^M)[z] polynomial multiply engine:
//            FSM state encoding and the helper functions that derive the
//            memory geometry (word width, row depth, product depth, address
//            width) from the engine parameters.
// Revision : 1.0 - initial release
// ============================================================================
package gf2mz_pkg;

    // Engine FSM state encoding
    localparam int                c_st_w    = 3;
    localparam logic [c_st_w-1:0] c_st_idle = 3'd0;
    localparam logic [c_st_w-1:0] c_st_clr  = 3'd1;
    localparam logic [c_st_w-1:0] c_st_rd   = 3'd2;
    localparam logic [c_st_w-1:0] c_st_mul  = 3'd3;
    localparam logic [c_st_w-1:0] c_st_crd  = 3'd4;
    localparam logic [c_st_w-1:0] c_st_acc  = 3'd5;
    localparam logic [c_st_w-1:0] c_st_tail = 3'd6;
    localparam logic [c_st_w-1:0] c_st_fin  = 3'd7;

    // Smallest r with 2**r >= value
    function automatic int f_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Memory word width: D coefficients of M bits
    function automatic int f_width(input int m, input int d);
        return m * d;
    endfunction

    // Words needed to hold N coefficients
    function automatic int f_depth(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    // Words needed to hold the full 2N-1 coefficient product
    function automatic int f_cdepth(input int n, input int d);
        return 2 * f_depth(n, d);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gf2m_mul.sv
`default_nettype none
// ============================================================================
// Module   : gf2m_mul
// Purpose  : Bit-serial GF(2^M) multiplier over the pentanomial
//            x^M + x^K3 + x^K2 + x^K1 + 1. Operands are captured on the cycle
//            i_start is high, one product bit is folded in per cycle (MSB
//            first), and o_done rises once all M steps have completed. The
//            result is held until the next i_start.
// Ports    : clk, rst (sync, active-high), i_start, i_a, i_b -> o_res, o_done
// Revision : 1.0 - initial release
// ============================================================================
module gf2m_mul
    import gf2mz_pkg::*;
#(
    parameter int M  = 83,
    parameter int K3 = 7,
    parameter int K2 = 4,
    parameter int K1 = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [M-1:0] i_a,
    input  logic [M-1:0] i_b,
    output logic [M-1:0] o_res,
    output logic         o_done
);

    localparam int           c_cnt_w = f_clog2(M + 1);
    localparam logic [M-1:0] c_poly  = M'(1) | (M'(1) << K1) | (M'(1) << K2) | (M'(1) << K3);

    logic [M-1:0]       r_a_q,   w_a_d;
    logic [M-1:0]       r_b_q,   w_b_d;
    logic [M-1:0]       r_acc_q, w_acc_d;
    logic [c_cnt_w-1:0] r_cnt_q, w_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_q   <= '0;
            r_b_q   <= '0;
            r_acc_q <= '0;
            r_cnt_q <= '0;
        end else begin
            r_a_q   <= w_a_d;
            r_b_q   <= w_b_d;
            r_acc_q <= w_acc_d;
            r_cnt_q <= w_cnt_d;
        end
    end

    // Horner step: acc = acc*x mod P + b_msb*a; b shifts left so its MSB is
    // always the next bit to consume.
    always_comb begin
        w_a_d   = r_a_q;
        w_b_d   = r_b_q;
        w_acc_d = r_acc_q;
        w_cnt_d = r_cnt_q;
        if (i_start) begin
            w_a_d   = i_a;
            w_b_d   = i_b;
            w_acc_d = '0;
            w_cnt_d = c_cnt_w'(M);
        end else if (r_cnt_q != '0) begin
            w_acc_d = {r_acc_q[M-2:0], 1'b0}
                    ^ (r_acc_q[M-1] ? c_poly : '0)
                    ^ (r_b_q[M-1]   ? r_a_q  : '0);
            w_b_d   = {r_b_q[M-2:0], 1'b0};
            w_cnt_d = r_cnt_q - c_cnt_w'(1);
        end
    end

    assign o_res  = r_acc_q;
    assign o_done = (r_cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/gf2mz_pp_fold.sv
`default_nettype none
// ============================================================================
// Module   : gf2mz_pp_fold
// Purpose  : Folds the D x D array of GF(2^M) products into 2D-1 partial
//            sums: sum k is the XOR of every product (r,s) with r+s = k.
// Ports    : i_prod  - D*D products, product (r,s) at slot r*D+s
//            o_psum  - 2D-1 sums, sum k at slot k
// Revision : 1.0 - initial release
// ============================================================================
module gf2mz_pp_fold #(
    parameter int M = 83,
    parameter int D = 5
) (
    input  logic [D*D*M-1:0]     i_prod,
    output logic [(2*D-1)*M-1:0] o_psum
);

    always_comb begin
        o_psum = '0;
        for (int r = 0; r < D; r++) begin
            for (int s = 0; s < D; s++) begin
                o_psum[(r+s)*M +: M] = o_psum[(r+s)*M +: M] ^ i_prod[(r*D+s)*M +: M];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gf2mz_mul_engine.sv
`default_nettype none
// ============================================================================
// Module   : gf2mz_mul_engine
// Purpose  : Word-serial schoolbook multiplier of two N-coefficient
//            polynomials over GF(2^M). Operands A, B and the product C live in
//            external memories with D coefficients per word. mode=0 produces
//            the full 2N-1 coefficient product, mode=1 the product reduced
//            mod z^N-1 (requires N divisible by D, otherwise err is raised).
// Ports    : clk, rst_b (sync, active-high)
//            start, mode            - request and product type
//            A_addr/A_di, B_addr/B_di - operand reads, 1-cycle latency
//            C_addr/C_we/C_do/C_di  - product read-modify-write port
//            busy, done, err        - status; err is valid with done
// Revision : 1.0 - initial release
// ============================================================================
module gf2mz_mul_engine
    import gf2mz_pkg::*;
#(
    parameter int N  = 149,
    parameter int M  = 83,
    parameter int K3 = 7,
    parameter int K2 = 4,
    parameter int K1 = 2,
    parameter int D  = 5,
    localparam int c_w      = f_width(M, D),
    localparam int c_depth  = f_depth(N, D),
    localparam int c_cdepth = f_cdepth(N, D),
    localparam int c_aw     = f_clog2(c_cdepth)
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            start,
    input  logic            mode,
    output logic [c_aw-1:0] A_addr,
    input  logic [c_w-1:0]  A_di,
    output logic [c_aw-1:0] B_addr,
    input  logic [c_w-1:0]  B_di,
    output logic [c_aw-1:0] C_addr,
    output logic            C_we,
    output logic [c_w-1:0]  C_do,
    input  logic [c_w-1:0]  C_di,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [c_aw-1:0] c_one_a     = c_aw'(1);
    localparam logic [c_aw-1:0] c_depth_a   = c_aw'(c_depth);
    localparam logic [c_aw-1:0] c_last_row  = c_aw'(c_depth - 1);
    localparam logic [c_aw-1:0] c_last_full = c_aw'(c_cdepth - 1);
    localparam bit              c_cyc_bad   = (N % D) != 0;

    logic [c_st_w-1:0] r_state_q,     w_state_d;
    logic              r_mode_q,      w_mode_d;
    logic              r_err_q,       w_err_d;
    logic [c_aw-1:0]   r_i_q,         w_i_d;
    logic [c_aw-1:0]   r_j_q,         w_j_d;     // also the CLR word counter
    logic [c_w-1:0]    r_carry_q,     w_carry_d;
    logic              r_mul_start_q, w_mul_start_d;
    logic              r_tail_wr_q,   w_tail_wr_d;

    logic [c_w-1:0]           w_a_coef, w_b_coef;
    logic [D*D*M-1:0]         w_prod;
    logic [D*D-1:0]           w_mul_done;
    logic                     w_all_done;
    logic [(2*D-1)*M-1:0]     w_psum;
    logic [c_w-1:0]           w_low, w_high;
    logic [c_aw-1:0]          w_ij, w_ij_addr, w_tail_addr;

    // Pad coefficients beyond index N-1 are forced to zero on the way in
    always_comb begin
        w_a_coef = A_di;
        w_b_coef = B_di;
        for (int t = 0; t < D; t++) begin
            if (int'(r_i_q) * D + t >= N) w_a_coef[t*M +: M] = '0;
            if (int'(r_j_q) * D + t >= N) w_b_coef[t*M +: M] = '0;
        end
    end

    for (genvar r = 0; r < D; r++) begin : g_row
        for (genvar s = 0; s < D; s++) begin : g_col
            gf2m_mul #(
                .M  (M),
                .K3 (K3),
                .K2 (K2),
                .K1 (K1)
            ) u_mul (
                .clk     (clk),
                .rst     (rst_b),
                .i_start (r_mul_start_q),
                .i_a     (w_a_coef[r*M +: M]),
                .i_b     (w_b_coef[s*M +: M]),
                .o_res   (w_prod[(r*D+s)*M +: M]),
                .o_done  (w_mul_done[r*D+s])
            );
        end
    end

    assign w_all_done = &w_mul_done;

    gf2mz_pp_fold #(
        .M (M),
        .D (D)
    ) u_fold (
        .i_prod (w_prod),
        .o_psum (w_psum)
    );

    // Sums 0..D-1 land in word i+j; sums D..2D-2 spill into word i+j+1
    assign w_low = w_psum[c_w-1:0];
    always_comb begin
        w_high = '0;
        for (int t = 0; t < D - 1; t++) begin
            w_high[t*M +: M] = w_psum[(D+t)*M +: M];
        end
    end

    // i,j < DEPTH, so a single conditional subtract implements mod DEPTH
    assign w_ij        = r_i_q + r_j_q;
    assign w_ij_addr   = (r_mode_q && (w_ij >= c_depth_a)) ? (w_ij - c_depth_a) : w_ij;
    assign w_tail_addr = r_mode_q ? r_i_q : (r_i_q + c_depth_a);

    // State register
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state_q     <= c_st_idle;
            r_mode_q      <= 1'b0;
            r_err_q       <= 1'b0;
            r_i_q         <= '0;
            r_j_q         <= '0;
            r_carry_q     <= '0;
            r_mul_start_q <= 1'b0;
            r_tail_wr_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_mode_q      <= w_mode_d;
            r_err_q       <= w_err_d;
            r_i_q         <= w_i_d;
            r_j_q         <= w_j_d;
            r_carry_q     <= w_carry_d;
            r_mul_start_q <= w_mul_start_d;
            r_tail_wr_q   <= w_tail_wr_d;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d     = r_state_q;
        w_mode_d      = r_mode_q;
        w_err_d       = r_err_q;
        w_i_d         = r_i_q;
        w_j_d         = r_j_q;
        w_carry_d     = r_carry_q;
        w_mul_start_d = 1'b0;
        w_tail_wr_d   = r_tail_wr_q;
        case (r_state_q)
            c_st_idle: begin
                if (start) begin
                    w_mode_d = mode;
                    w_j_d    = '0;
                    if (mode && c_cyc_bad) begin
                        w_err_d   = 1'b1;
                        w_state_d = c_st_fin;
                    end else begin
                        w_err_d   = 1'b0;
                        w_state_d = c_st_clr;
                    end
                end
            end
            c_st_clr: begin
                if (r_j_q == (r_mode_q ? c_last_row : c_last_full)) begin
                    w_i_d     = '0;
                    w_j_d     = '0;
                    w_carry_d = '0;
                    w_state_d = c_st_rd;
                end else begin
                    w_j_d = r_j_q + c_one_a;
                end
            end
            c_st_rd: begin
                w_mul_start_d = 1'b1;
                w_state_d     = c_st_mul;
            end
            c_st_mul: begin
                // The start cycle still shows the previous done level
                if (!r_mul_start_q && w_all_done) begin
                    w_state_d = c_st_crd;
                end
            end
            c_st_crd: begin
                w_state_d = c_st_acc;
            end
            c_st_acc: begin
                w_carry_d   = w_high;
                w_tail_wr_d = 1'b0;
                if (r_j_q < c_last_row) begin
                    w_j_d     = r_j_q + c_one_a;
                    w_state_d = c_st_rd;
                end else begin
                    w_state_d = c_st_tail;
                end
            end
            c_st_tail: begin
                if (!r_tail_wr_q) begin
                    w_tail_wr_d = 1'b1;
                end else begin
                    w_tail_wr_d = 1'b0;
                    w_carry_d   = '0;
                    w_j_d       = '0;
                    w_i_d       = r_i_q + c_one_a;
                    w_state_d   = (r_i_q < c_last_row) ? c_st_rd : c_st_fin;
                end
            end
            c_st_fin: begin
                w_state_d = c_st_idle;
            end
            default: begin
                w_state_d = c_st_idle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        A_addr = '0;
        B_addr = '0;
        C_addr = '0;
        C_we   = 1'b0;
        C_do   = '0;
        busy   = (r_state_q != c_st_idle);
        done   = (r_state_q == c_st_fin);
        err    = r_err_q;
        case (r_state_q)
            c_st_clr: begin
                C_addr = r_j_q;
                C_we   = 1'b1;
            end
            c_st_rd: begin
                A_addr = r_i_q;
                B_addr = r_j_q;
            end
            c_st_crd: begin
                C_addr = w_ij_addr;
            end
            c_st_acc: begin
                C_addr = w_ij_addr;
                C_we   = 1'b1;
                C_do   = C_di ^ w_low ^ r_carry_q;
            end
            c_st_tail: begin
                C_addr = w_tail_addr;
                C_we   = r_tail_wr_q;
                C_do   = r_tail_wr_q ? (C_di ^ r_carry_q) : '0;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_gf2mz_mul_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf2mz_mul_engine
// Purpose  : Self-checking bench for gf2mz_mul_engine with N=10, M=8, D=2 over
//            x^8+x^4+x^3+x+1, plus a second N=9 instance for the cyclic error
//            path. Results are compared with a coefficient-level schoolbook
//            model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gf2mz_mul_engine;

    localparam int N       = 10;
    localparam int M       = 8;
    localparam int D       = 2;
    localparam int K3      = 4;
    localparam int K2      = 3;
    localparam int K1      = 1;
    localparam int DEPTH   = (N + D - 1) / D;
    localparam int CDEPTH  = 2 * DEPTH;
    localparam int W       = M * D;
    localparam int AW      = $clog2(CDEPTH);
    localparam int N2      = 9;
    localparam int AW2     = $clog2(2 * ((N2 + D - 1) / D));
    // Bit-serial multiplier: start cycle, M steps, one cycle to see done
    localparam int MUL_LAT = M + 2;

    logic          clk = 1'b0;
    logic          rst_b = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] A_addr, B_addr, C_addr;
    logic [W-1:0]  A_di, B_di, C_di, C_do;
    logic          C_we, busy, done, err;

    logic           start2 = 1'b0;
    logic           mode2 = 1'b0;
    logic [AW2-1:0] A_addr2, B_addr2, C_addr2;
    logic [W-1:0]   A_di2 = '0, B_di2 = '0, C_di2 = '0, C_do2;
    logic           C_we2, busy2, done2, err2;
    logic           we2_seen = 1'b0;

    logic [W-1:0] a_mem [16];
    logic [W-1:0] b_mem [16];
    logic [W-1:0] c_mem [16];
    logic [M-1:0] exp_c [CDEPTH*D];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gf2mz_mul_engine #(.N(N), .M(M), .K3(K3), .K2(K2), .K1(K1), .D(D)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .mode(mode),
        .A_addr(A_addr), .A_di(A_di), .B_addr(B_addr), .B_di(B_di),
        .C_addr(C_addr), .C_we(C_we), .C_do(C_do), .C_di(C_di),
        .busy(busy), .done(done), .err(err)
    );

    gf2mz_mul_engine #(.N(N2), .M(M), .K3(K3), .K2(K2), .K1(K1), .D(D)) dut2 (
        .clk(clk), .rst_b(rst_b), .start(start2), .mode(mode2),
        .A_addr(A_addr2), .A_di(A_di2), .B_addr(B_addr2), .B_di(B_di2),
        .C_addr(C_addr2), .C_we(C_we2), .C_do(C_do2), .C_di(C_di2),
        .busy(busy2), .done(done2), .err(err2)
    );

    // External memories with one-cycle read latency
    always @(posedge clk) begin
        A_di <= a_mem[A_addr];
        B_di <= b_mem[B_addr];
        C_di <= c_mem[C_addr];
        if (C_we) c_mem[C_addr] <= C_do;
        if (C_we2) we2_seen <= 1'b1;
    end

    // ---------------- reference model ----------------
    function automatic logic [M-1:0] gmul(input logic [M-1:0] a_in, input logic [M-1:0] b_in);
        logic [M-1:0] a, b, r, poly_lo;
        a = a_in; b = b_in; r = '0;
        poly_lo = M'((1 << K3) | (1 << K2) | (1 << K1) | 1);
        for (int i = 0; i < M; i++) begin
            if (b[0]) r = r ^ a;
            a = a[M-1] ? ((a << 1) ^ poly_lo) : (a << 1);
            b = b >> 1;
        end
        return r;
    endfunction

    function automatic logic [M-1:0] coef_of(input logic [W-1:0] word, input int t);
        return word[t*M +: M];
    endfunction

    task automatic build_expected(input bit m);
        logic [M-1:0] ca, cb;
        for (int k = 0; k < CDEPTH * D; k++) exp_c[k] = '0;
        for (int p = 0; p < N; p++) begin
            for (int q = 0; q < N; q++) begin
                ca = coef_of(a_mem[p / D], p % D);
                cb = coef_of(b_mem[q / D], q % D);
                if (m) exp_c[(p + q) % N] = exp_c[(p + q) % N] ^ gmul(ca, cb);
                else   exp_c[p + q]       = exp_c[p + q] ^ gmul(ca, cb);
            end
        end
    endtask

    function automatic int exp_cycles(input bit m);
        int clr;
        clr = m ? DEPTH : CDEPTH;
        // clear + per row (pairs of RD,MUL,CRD,ACC + 2 TAIL) + FIN
        return clr + DEPTH * (DEPTH * (1 + MUL_LAT + 1 + 1) + 2) + 1;
    endfunction

    task automatic randomize_ops();
        for (int w = 0; w < 16; w++) begin
            a_mem[w] = W'($urandom);
            b_mem[w] = W'($urandom);
        end
    endtask

    // Runs one operation; extra_at > 0 pulses start again at that cycle
    task automatic run_op(input bit m, input int extra_at, output int cyc,
                          output bit timed_out, output bit err_seen,
                          output bit done_after, output bit busy_after);
        @(posedge clk); #1;
        start = 1'b1; mode = m;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; timed_out = 1'b1; err_seen = 1'b0;
        done_after = 1'b0; busy_after = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            cyc++;
            if (cyc == extra_at) start = 1'b1;
            if (cyc == extra_at + 1) start = 1'b0;
            if (done) begin
                timed_out = 1'b0;
                err_seen  = err;
                break;
            end
        end
        @(negedge clk);
        start      = 1'b0;
        done_after = done;
        busy_after = busy;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (C_we !== 1'b0) begin errors++; $display("FAIL reset_cwe: got %b expected 0", C_we); end
        checks++; if ({A_addr, B_addr, C_addr} !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", {A_addr, B_addr, C_addr}); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy2: got %b expected 0", busy2); end
    endtask

    task automatic test_identity();
        int cyc; bit to, e, da, ba;
        logic [M-1:0] got, want;
        randomize_ops();
        for (int w = 0; w < DEPTH; w++) a_mem[w] = '0;
        a_mem[0] = W'(1);
        run_op(1'b0, 0, cyc, to, e, da, ba);
        checks++; if (to) begin errors++; $display("FAIL ident_timeout: got no done expected done"); end
        checks++; if (cyc !== exp_cycles(1'b0)) begin errors++; $display("FAIL ident_cycles: got %0d expected %0d", cyc, exp_cycles(1'b0)); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL ident_err: got %b expected 0", e); end
        checks++; if (da !== 1'b0) begin errors++; $display("FAIL ident_done_width: got %b expected 0", da); end
        for (int k = 0; k < CDEPTH * D; k++) begin
            got  = coef_of(c_mem[k / D], k % D);
            want = (k < N) ? coef_of(b_mem[k / D], k % D) : '0;
            checks++;
            if (got !== want) begin errors++; $display("FAIL ident_c k=%0d: got %h expected %h", k, got, want); end
        end
    endtask

    task automatic test_monomial();
        int cyc; bit to, e, da, ba;
        logic [M-1:0] got, want;
        for (int mi = 1; mi >= 0; mi--) begin
            for (int w = 0; w < 16; w++) begin a_mem[w] = '0; b_mem[w] = '0; end
            a_mem[0] = W'(1) << M;                       // z
            b_mem[(N - 1) / D] = W'(1) << (((N - 1) % D) * M); // z^(N-1)
            run_op(mi[0], 0, cyc, to, e, da, ba);
            checks++; if (to) begin errors++; $display("FAIL mono_timeout m=%0d: got no done expected done", mi); end
            for (int k = 0; k < (mi ? N : CDEPTH * D); k++) begin
                got  = coef_of(c_mem[k / D], k % D);
                want = (k == (mi ? 0 : N)) ? M'(1) : M'(0);
                checks++;
                if (got !== want) begin errors++; $display("FAIL mono_c m=%0d k=%0d: got %h expected %h", mi, k, got, want); end
            end
        end
    endtask

    task automatic test_err_path();
        int cyc; bit found;
        @(posedge clk); #1;
        start2 = 1'b1; mode2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        cyc = 0; found = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            cyc++;
            if (done2) begin
                found = 1'b1;
                checks++;
                if (err2 !== 1'b1) begin errors++; $display("FAIL err_flag: got %b expected 1", err2); end
                break;
            end
        end
        checks++; if (!found || cyc > 2) begin errors++; $display("FAIL err_latency: got %0d cycles found=%0d expected <=2", cyc, found); end
        repeat (4) @(negedge clk);
        checks++; if (we2_seen !== 1'b0) begin errors++; $display("FAIL err_cwe: got %b expected 0", we2_seen); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL err_idle: got %b expected 0", busy2); end
    endtask

    task automatic test_random(input int iters, input int extra_kind);
        int cyc, extra; bit to, e, da, ba, m;
        logic [M-1:0] got;
        for (int it = 0; it < iters; it++) begin
            m = it[0];
            randomize_ops();
            build_expected(m);
            // extra_kind: 0 none, 1 start mid-run, 2 start on the done cycle
            extra = (extra_kind == 1) ? 20 + int'($urandom_range(0, 200)) :
                    (extra_kind == 2) ? exp_cycles(m) : 0;
            run_op(m, extra, cyc, to, e, da, ba);
            checks++; if (to) begin errors++; $display("FAIL rand_timeout k%0d it%0d: got no done expected done", extra_kind, it); end
            checks++; if (cyc !== exp_cycles(m)) begin errors++; $display("FAIL rand_cycles k%0d it%0d: got %0d expected %0d", extra_kind, it, cyc, exp_cycles(m)); end
            checks++; if (e !== 1'b0) begin errors++; $display("FAIL rand_err k%0d it%0d: got %b expected 0", extra_kind, it, e); end
            checks++; if (da !== 1'b0 || ba !== 1'b0) begin errors++; $display("FAIL rand_after_done k%0d it%0d: got done=%b busy=%b expected 0 0", extra_kind, it, da, ba); end
            for (int k = 0; k < (m ? N : CDEPTH * D); k++) begin
                got = coef_of(c_mem[k / D], k % D);
                checks++;
                if (got !== exp_c[k]) begin errors++; $display("FAIL rand_c k%0d it%0d m=%0d k=%0d: got %h expected %h", extra_kind, it, m, k, got, exp_c[k]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done, saw_we;
        randomize_ops();
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        // cycles 1..10 clear, 11 read, 12.. multiply
        repeat (14) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (C_we !== 1'b0) begin errors++; $display("FAIL midrst_cwe: got %b expected 0", C_we); end
        saw_done = 1'b0; saw_we = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
            if (C_we) saw_we = 1'b1;
        end
        checks++; if (saw_done || saw_we) begin errors++; $display("FAIL midrst_quiet: got done=%b we=%b expected 0 0", saw_done, saw_we); end
        test_random(2, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b0;
        test_reset();
        test_identity();
        test_monomial();
        test_err_path();
        test_random(4, 0);
        test_random(2, 1);
        test_random(2, 2);
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
